// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle unsigned multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply or restoring divide, one bit per cycle; HI/LO commit on entry to FIN.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int         CW     = $clog2(ITERS + 1);
   localparam logic [3:0] OP_MUL = 4'h3;
   localparam logic [3:0] OP_DIV = 4'h4;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q, done_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     quot_q, quot_d;
   logic [WIDTH-1:0]     dvsr_q;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;

   // acc holds {partial product, remaining multiplier bits}; the sum carry lands in the top bit.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
      rem_d     = div_shift;
      quot_d    = {quot_q[WIDTH-2:0], 1'b0};
      if (div_shift >= {1'b0, dvsr_q}) begin
         rem_d  = div_shift - {1'b0, dvsr_q};
         quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mthi_we) hi_q <= wdata;
               if (mtlo_we) lo_q <= wdata;
               if (start && op == OP_MUL) begin
                  state_q <= S_MUL;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(ITERS);
                  acc_q   <= {{WIDTH{1'b0}}, y};
                  mcand_q <= x;
               end else if (start && op == OP_DIV) begin
                  state_q <= S_DIV;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(ITERS);
                  rem_q   <= '0;
                  quot_q  <= x;
                  dvsr_q  <= y;
               end
            end
            S_MUL: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= S_FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hi_q    <= acc_d[2*WIDTH-1:WIDTH];
                  lo_q    <= acc_d[WIDTH-1:0];
               end
            end
            S_DIV: begin
               rem_q  <= rem_d;
               quot_q <= quot_d;
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= S_FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hi_q    <= rem_d[WIDTH-1:0];
                  lo_q    <= quot_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
